// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with per-entry busy scoreboard, same-cycle writeback bypass, and registered busy count.
// Reads are combinational with no wait state; there is no backpressure apart from iss_stall holding a dependent issue.
// Define REG_ZERO_EN to hardwire entry 0 to zero and keep it permanently not busy.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              SYS_reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_stall,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_count,
  input  logic [ADDR_W-1:0] test_addr,
  output logic [DATA_W-1:0] test_data
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
`ifdef REG_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              wr_ok;
  logic              iss_ok;
  logic              hit1;
  logic              hit2;
  logic              hit_iss;

  // A write to a hardwired-zero entry is dropped everywhere, including the bypass.
  assign wr_ok   = wr_en & ~(ZERO_EN & (wr_addr == '0));
  assign hit1    = wr_en & (wr_addr == rd_addr1);
  assign hit2    = wr_en & (wr_addr == rd_addr2);
  assign hit_iss = wr_en & (wr_addr == iss_addr);

  assign rd_data1  = SYS_reset ? '0 : ((wr_ok & hit1) ? wr_data : mem[rd_addr1]);
  assign rd_data2  = SYS_reset ? '0 : ((wr_ok & hit2) ? wr_data : mem[rd_addr2]);
  assign test_data = SYS_reset ? '0 : mem[test_addr];
  assign rd_busy1  = ~SYS_reset & busy[rd_addr1] & ~hit1;
  assign rd_busy2  = ~SYS_reset & busy[rd_addr2] & ~hit2;
  assign iss_stall = ~SYS_reset & busy[iss_addr] & ~hit_iss;

  assign iss_ok = iss_en & ~iss_stall & ~flush & ~(ZERO_EN & (iss_addr == '0));

  // Retire first, then issue, so a same-cycle reissue of the retiring entry leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) busy_nxt[wr_addr] = 1'b0;
    if (flush) busy_nxt = '0;
    else if (iss_ok) busy_nxt[iss_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
  end

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and randomized bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;
`ifdef REG_ZERO_EN
  localparam bit ZE = 1'b1;
`else
  localparam bit ZE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          SYS_reset;
  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, iss_addr, test_addr;
  logic [DW-1:0] rd_data1, rd_data2, wr_data, test_data;
  logic          rd_busy1, rd_busy2, wr_en, iss_en, iss_stall, flush;
  logic [AW:0]   busy_count;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .SYS_reset(SYS_reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(iss_stall),
    .flush(flush), .busy_count(busy_count),
    .test_addr(test_addr), .test_data(test_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]    m [DEPTH];
  bit   [DEPTH-1:0] bsy;
  int errs = 0;
  int checks = 0;
  logic last_stall, last_busy1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (wr_en && wr_addr == a && !(ZE && a == 0)) return wr_data;
    return m[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return bsy[a] && !(wr_en && wr_addr == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    bsy = '0;
  endtask

  // Apply one cycle of inputs (called just after a falling edge), check combinational
  // outputs before the rising edge, advance the model, check registered outputs after.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic ie, input logic [AW-1:0] ia, input logic fl,
                      input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                      input logic [AW-1:0] ta);
    logic stl;
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; flush = fl;
    rd_addr1 = ra1; rd_addr2 = ra2; test_addr = ta;
    #1;
    chk("rd_data1", rd_data1, exp_rd(ra1));
    chk("rd_data2", rd_data2, exp_rd(ra2));
    chk("rd_busy1", rd_busy1, exp_busy(ra1));
    chk("rd_busy2", rd_busy2, exp_busy(ra2));
    stl = exp_busy(ia);
    chk("iss_stall", iss_stall, stl);
    chk("test_data_pre", test_data, m[ta]);
    last_stall = iss_stall;
    last_busy1 = rd_busy1;
    @(posedge clk);
    if (we && !(ZE && wa == 0)) m[wa] = wd;
    if (we) bsy[wa] = 1'b0;
    if (fl) bsy = '0;
    else if (ie && !stl && !(ZE && ia == 0)) bsy[ia] = 1'b1;
    @(negedge clk);
    chk("busy_count", busy_count, $countones(bsy));
    chk("test_data_post", test_data, m[ta]);
  endtask

  initial begin
    SYS_reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_F00D;
    iss_en = 1'b0; iss_addr = 5'd0; flush = 1'b0;
    rd_addr1 = 5'd3; rd_addr2 = 5'd4; test_addr = 5'd3;
    model_reset();
    #1;
    chk("rst_rd_data1", rd_data1, 0);
    chk("rst_test_data", test_data, 0);
    chk("rst_busy_count", busy_count, 0);
    chk("rst_iss_stall", iss_stall, 0);
    @(negedge clk);
    wr_en = 1'b0;
    SYS_reset = 1'b0;

    // 1: every entry reads zero after reset
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr1 = AW'(i); rd_addr2 = AW'(DEPTH - 1 - i);
      #1;
      chk("t1_rd1", rd_data1, 0);
      chk("t1_rd2", rd_data2, 0);
    end
    chk("t1_cnt", busy_count, 0);
    @(negedge clk);

    // 2: write bypass visible before the edge, array only after
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 6, 5);
    chk("t2_test_data", test_data, 32'hDEADBEEF);

    // 3: double issue stalls; retire+reissue leaves entry busy
    step(0, 0, 0, 1, 7, 0, 7, 0, 7);
    step(0, 0, 0, 1, 7, 0, 7, 0, 7);
    chk("t3_stall", last_stall, 1);
    chk("t3_cnt1", busy_count, 1);
    step(1, 7, 32'h11, 1, 7, 0, 7, 0, 7);
    chk("t3_mem7", test_data, 32'h11);
    chk("t3_cnt2", busy_count, 1);
    step(0, 0, 0, 0, 0, 0, 7, 0, 7);
    chk("t3_busy7", last_busy1, 1);

    // 4: flush clears busy, concurrent write still lands
    step(1, 7, 32'h77, 0, 0, 0, 7, 0, 7);
    step(0, 0, 0, 1, 1, 0, 1, 2, 1);
    step(0, 0, 0, 1, 2, 0, 1, 2, 2);
    step(0, 0, 0, 1, 3, 0, 1, 2, 3);
    chk("t4_cnt3", busy_count, 3);
    step(1, 2, 32'h22, 1, 9, 1, 2, 3, 2);
    chk("t4_cnt0", busy_count, 0);
    chk("t4_mem2", test_data, 32'h22);

    // 5: entry 0 behaviour depends on REG_ZERO_EN
    step(1, 0, 32'hFFFF, 1, 0, 0, 0, 0, 0);
    chk("t5_r0", test_data, ZE ? 32'h0 : 32'hFFFF);
    chk("t5_cnt", busy_count, ZE ? 0 : 1);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);

    // randomized traffic, addresses biased low to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa, ia, r1, r2;
      wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ia = AW'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 1) == 0) ? ia : AW'($urandom);
      step(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ia,
           1'($urandom_range(0, 15) == 0), r1, r2, AW'($urandom_range(0, 7)));
    end

    // 6: asynchronous reset between edges drops state and the pending write
    step(1, 9, 32'hA5, 1, 9, 0, 9, 9, 9);
    chk("t6_mem9", test_data, 32'hA5);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    iss_en = 1'b1; iss_addr = 5'd9; flush = 1'b0;
    rd_addr1 = 5'd9; rd_addr2 = 5'd9; test_addr = 5'd9;
    #2 SYS_reset = 1'b1;
    #1;
    chk("t6_test_data", test_data, 0);
    chk("t6_cnt", busy_count, 0);
    chk("t6_rd1", rd_data1, 0);
    chk("t6_busy1", rd_busy1, 0);
    chk("t6_stall", iss_stall, 0);
    @(posedge clk);
    #1;
    chk("t6_held", test_data, 0);
    @(negedge clk);
    SYS_reset = 1'b0;
    wr_en = 1'b0; iss_en = 1'b0;
    model_reset();
    #1;
    chk("t6_after", test_data, 0);
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 9, 5, 5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
